universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/universal_shift_register.sv | 129 ++++++++++++
 tb/tb_universal_shift_register.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load plus multi-step shift/rotate
// operations sequenced by a two-state FSM with a done pulse.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       mode_r;
    logic [WIDTH-1:0] q_nx;
    logic             sout_nx;
    logic             last;

    assign last = (cnt == AMT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!load && start && amt != '0)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                if (last)
                    state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);

    // One step of the latched operation; mode 111 leaves everything as is.
    always_comb begin
        q_nx    = q;
        sout_nx = sout;
        unique case (mode_r)
            3'b000: begin
                q_nx    = {q[WIDTH-2:0], sin};
                sout_nx = q[WIDTH-1];
            end
            3'b001: begin
                q_nx    = {sin, q[WIDTH-1:1]};
                sout_nx = q[0];
            end
            3'b010: begin
                q_nx    = {q[WIDTH-2:0], q[WIDTH-1]};
                sout_nx = q[WIDTH-1];
            end
            3'b011: begin
                q_nx    = {q[0], q[WIDTH-1:1]};
                sout_nx = q[0];
            end
            3'b100: begin
                q_nx    = {q[WIDTH-1], q[WIDTH-1:1]};
                sout_nx = q[0];
            end
            3'b101: begin
                q_nx    = {q[WIDTH-2:0], 1'b0};
                sout_nx = q[WIDTH-1];
            end
            3'b110: begin
                q_nx    = {1'b0, q[WIDTH-1:1]};
                sout_nx = q[0];
            end
            default: begin
                q_nx    = q;
                sout_nx = sout;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            sout   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mode_r <= 3'b000;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        q <= din;
                    end else if (start) begin
                        mode_r <= mode;
                        cnt    <= amt;
                        if (amt == '0)
                            done <= 1'b1;
                    end
                end
                SHIFT: begin
                    q    <= q_nx;
                    sout <= sout_nx;
                    if (cnt != '0)
                        cnt <= cnt - AMT_W'(1);
                    if (last)
                        done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: table of single-cycle
// vectors plus hand sequences for reset, long counts and WIDTH=16.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = '0;
    logic       start = 1'b0;
    logic [2:0] mode = '0;
    logic [3:0] amt = '0;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout, busy, done;

    logic        w_load = 1'b0;
    logic [15:0] w_din = '0;
    logic        w_start = 1'b0;
    logic [2:0]  w_mode = '0;
    logic [4:0]  w_amt = '0;
    logic        w_sin = 1'b0;
    logic [15:0] w_q;
    logic        w_sout, w_busy, w_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    universal_shift_register dut (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .start(start), .mode(mode), .amt(amt), .sin(sin),
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    universal_shift_register #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .load(w_load), .din(w_din),
        .start(w_start), .mode(w_mode), .amt(w_amt), .sin(w_sin),
        .q(w_q), .sout(w_sout), .busy(w_busy), .done(w_done)
    );

    typedef struct {
        logic       load;
        logic [7:0] din;
        logic       start;
        logic [2:0] mode;
        logic [3:0] amt;
        logic       sin;
        logic [7:0] q;
        logic       sout;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic l, logic [7:0] d, logic s,
                         logic [2:0] m, logic [3:0] a, logic si);
        load = l; din = d; start = s; mode = m; amt = a; sin = si;
    endtask

    task automatic add(logic l, logic [7:0] d, logic s, logic [2:0] m,
                       logic [3:0] a, logic si, logic [7:0] eq,
                       logic es, logic eb, logic ed);
        vec_t v;
        v.load = l; v.din = d; v.start = s; v.mode = m; v.amt = a;
        v.sin = si; v.q = eq; v.sout = es; v.busy = eb; v.done = ed;
        vecs.push_back(v);
    endtask

    // Start an 8-bit op and follow it to done within a cycle budget.
    task automatic run_op(string name, logic [2:0] m, logic [3:0] a,
                          logic si, int exp_busy, logic [7:0] exp_q,
                          logic exp_sout);
        int nb;
        int nd;
        nb = 0;
        nd = 0;
        drive(1'b0, 8'h00, 1'b1, m, a, si);
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) begin
                nd++;
                break;
            end
            tick();
        end
        check({name, "_done"}, 64'(nd), 64'd1);
        check({name, "_busy"}, 64'(nb), 64'(exp_busy));
        check({name, "_q"}, 64'(q), 64'(exp_q));
        check({name, "_sout"}, 64'(sout), 64'(exp_sout));
        tick();
        check({name, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int nd;
        int nb;
        #2;
        check("rst_q", 64'(q), 64'd0);
        check("rst_flags", 64'({sout, busy, done}), 64'd0);
        rst = 1'b1;
        tick();

        add(1, 8'hA5, 0, 3'd0, 0, 0, 8'hA5, 0, 0, 0);
        add(0, 8'h00, 1, 3'd2, 3, 0, 8'hA5, 0, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 0, 8'h4B, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 0, 8'h96, 0, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 0, 8'h2D, 1, 0, 1);
        add(0, 8'h00, 0, 3'd0, 0, 0, 8'h2D, 1, 0, 0);
        add(1, 8'h81, 0, 3'd0, 0, 0, 8'h81, 1, 0, 0);
        add(0, 8'h00, 1, 3'd4, 2, 0, 8'h81, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 0, 8'hC0, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 0, 8'hE0, 0, 0, 1);
        add(0, 8'h00, 0, 3'd0, 0, 0, 8'hE0, 0, 0, 0);
        add(1, 8'h00, 0, 3'd0, 0, 1, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 3'd0, 4, 1, 8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h01, 0, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h03, 0, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h07, 0, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h0F, 0, 0, 1);
        add(0, 8'h00, 1, 3'd1, 4, 1, 8'h0F, 0, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h87, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'hC3, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'hE1, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'hF0, 1, 0, 1);
        add(0, 8'h00, 1, 3'd0, 0, 1, 8'hF0, 1, 0, 1);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'hF0, 1, 0, 0);
        add(1, 8'h5A, 1, 3'd0, 3, 1, 8'h5A, 1, 0, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h5A, 1, 0, 0);
        add(0, 8'h00, 1, 3'd3, 2, 0, 8'h5A, 1, 1, 0);
        add(1, 8'h3C, 1, 3'd0, 7, 0, 8'h2D, 0, 1, 0);
        add(1, 8'h3C, 0, 3'd0, 0, 0, 8'h96, 1, 0, 1);
        add(0, 8'h00, 1, 3'd7, 2, 1, 8'h96, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h96, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h96, 1, 0, 1);
        add(1, 8'h81, 0, 3'd0, 0, 1, 8'h81, 1, 0, 0);
        add(0, 8'h00, 1, 3'd5, 1, 1, 8'h81, 1, 1, 0);
        add(0, 8'h00, 0, 3'd0, 0, 1, 8'h02, 1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].din, vecs[i].start,
                  vecs[i].mode, vecs[i].amt, vecs[i].sin);
            tick();
            check($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
            check($sformatf("vec%0d_flags", i),
                  64'({sout, busy, done}),
                  64'({vecs[i].sout, vecs[i].busy, vecs[i].done}));
        end
        drive(0, 8'h00, 0, 3'd0, 0, 0);

        // Counts beyond WIDTH run in full.
        run_op("rol9", 3'd2, 4'd9, 1'b0, 9, 8'h04, 1'b0);
        drive(1, 8'hFF, 0, 3'd0, 0, 1);
        tick();
        load = 1'b0;
        run_op("shr0_10", 3'd6, 4'd10, 1'b1, 10, 8'h00, 1'b0);

        // Asynchronous reset mid-cycle.
        drive(1, 8'hFF, 0, 3'd0, 0, 1);
        tick();
        load = 1'b0;
        check("pre_rst_q", 64'(q), 64'hFF);
        #2 rst = 1'b0;
        #1;
        check("async_rst_q", 64'(q), 64'd0);
        check("async_rst_flags", 64'({sout, busy, done}), 64'd0);
        rst = 1'b1;
        tick();

        // Reset after 2 of 5 steps aborts with no done.
        drive(1, 8'hA5, 0, 3'd0, 0, 0);
        tick();
        drive(0, 8'h00, 1, 3'd2, 5, 0);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_mid_q", 64'(q), 64'h96);
        #2 rst = 1'b0;
        #1;
        check("abort_flags", 64'({q, sout, busy, done}), 64'd0);
        rst = 1'b1;
        drive(1, 8'h11, 0, 3'd0, 0, 0);
        tick();
        check("post_rst_load", 64'(q), 64'h11);
        load = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) nd++;
            tick();
        end
        check("abort_no_done", 64'(nd), 64'd0);

        // WIDTH=16 full rotation returns to the loaded value.
        w_load = 1'b1;
        w_din = 16'h1234;
        tick();
        w_load = 1'b0;
        check("w16_load", 64'(w_q), 64'h1234);
        w_start = 1'b1;
        w_mode = 3'd3;
        w_amt = 5'd16;
        tick();
        w_start = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (w_busy) nb++;
            if (w_done) nd++;
            tick();
        end
        check("w16_busy", 64'(nb), 64'd16);
        check("w16_done", 64'(nd), 64'd1);
        check("w16_q", 64'(w_q), 64'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
